// File: rtl/imm_ext_pkg.sv
// +--------------------------------------------------------------------------+
// | imm_ext_pkg : shared types and constants for the immediate extender      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package imm_ext_pkg;

  typedef enum logic [1:0] {
    IMM_SEXT  = 2'd0,
    IMM_ZEXT  = 2'd1,
    IMM_UPPER = 2'd2,
    IMM_RSVD  = 2'd3
  } imm_mode_e;

  localparam int BUF_DEPTH = 2;

endpackage : imm_ext_pkg

`default_nettype wire

// File: rtl/imm_ext_skid.sv
// +--------------------------------------------------------------------------+
// | imm_ext_skid : 2-entry registered valid/ready FIFO buffer                |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module imm_ext_skid
  import imm_ext_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OUT_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
);

  localparam logic [1:0] FULL_CNT = 2'(BUF_DEPTH);

  logic [1:0]       count_q, count_d;
  logic [OUT_W-1:0] head_q, head_d;
  logic [OUT_W-1:0] tail_q, tail_d;
  logic             w_push, w_pop;

  // Handshake flags come straight from the occupancy register, so in_ready
  // never depends combinationally on out_ready.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (count_q)
      2'd0: begin
        if (w_push) begin
          head_d  = in_data;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (w_push && w_pop) begin
          head_d = in_data;
        end else if (w_push) begin
          tail_d  = in_data;
          count_d = 2'd2;
        end else if (w_pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        if (w_pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule : imm_ext_skid

`default_nettype wire

// File: rtl/imm_extend_pipe.sv
// +--------------------------------------------------------------------------+
// | imm_extend_pipe : sign/zero/upper immediate extension into a 2-entry     |
// | elastic buffer. IMM_EXT_SHIFT_EN adds in_shamt and a 0..3 left shift.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 28,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
`ifdef IMM_EXT_SHIFT_EN
  input  logic [1:0]       in_shamt,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm
);

  logic [OUT_W-1:0] w_ext;
  logic [OUT_W-1:0] w_shifted;

  generate
    if (IN_W == OUT_W) begin : g_pass
      // No room to extend: every mode is a plain pass-through.
      assign w_ext = in_imm;
    end else begin : g_ext
      localparam int PAD_W = OUT_W - IN_W;
      always_comb begin
        case (imm_mode_e'(in_mode))
          IMM_SEXT:  w_ext = {{PAD_W{in_imm[IN_W-1]}}, in_imm};
          IMM_UPPER: w_ext = {in_imm, {PAD_W{1'b0}}};
          default:   w_ext = {{PAD_W{1'b0}}, in_imm};
        endcase
      end
    end
  endgenerate

`ifdef IMM_EXT_SHIFT_EN
  assign w_shifted = w_ext << in_shamt;
`else
  assign w_shifted = w_ext;
`endif

  imm_ext_skid #(
    .OUT_W (OUT_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_shifted),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_imm)
  );

endmodule : imm_extend_pipe

`default_nettype wire
